// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory.
// Port A (CPU load/store) and port B (loader/debug DMA) are serialised
// through IDLE -> ACCESS -> ACK. Ties go round-robin; out-of-range word
// addresses skip the memory and complete one cycle early with err set.
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(DEPTH);

    state_t            state_reg, state_next;
    logic              last_b_reg, last_b_next;     // 1 = B won the most recent tie
    logic              grant_b_reg, grant_b_next;   // port owning the current access
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] mem_address_reg, mem_address_next;
    logic [DATA_W-1:0] mem_data_in_reg, mem_data_in_next;
    logic              mem_write_reg, mem_write_next;
    logic              mem_read_reg, mem_read_next;
    logic              a_ack_reg, a_ack_next;
    logic              a_err_reg, a_err_next;
    logic [DATA_W-1:0] a_rdata_reg, a_rdata_next;
    logic              b_ack_reg, b_ack_next;
    logic              b_err_reg, b_err_next;
    logic [DATA_W-1:0] b_rdata_reg, b_rdata_next;
    logic              busy_reg, busy_next;

    // Candidate selection in IDLE: B wins when alone, or on a tie when A won last.
    logic              sel_b;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign sel_b     = b_req && (!a_req || !last_b_reg);
    assign sel_we    = sel_b ? b_we    : a_we;
    assign sel_addr  = sel_b ? b_addr  : a_addr;
    assign sel_wdata = sel_b ? b_wdata : a_wdata;

    // Next-state, arbitration and output decode; strobes and acks default low.
    always_comb begin
        state_next       = state_reg;
        last_b_next      = last_b_reg;
        grant_b_next     = grant_b_reg;
        we_next          = we_reg;
        mem_address_next = mem_address_reg;
        mem_data_in_next = mem_data_in_reg;
        mem_write_next   = 1'b0;
        mem_read_next    = 1'b0;
        a_ack_next       = 1'b0;
        a_err_next       = 1'b0;
        a_rdata_next     = a_rdata_reg;
        b_ack_next       = 1'b0;
        b_err_next       = 1'b0;
        b_rdata_next     = b_rdata_reg;
        busy_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (a_req || b_req) begin
                    grant_b_next = sel_b;
                    we_next      = sel_we;
                    busy_next    = 1'b1;
                    if (a_req && b_req) begin
                        last_b_next = sel_b;
                    end
                    if (sel_addr < DEPTH_LIMIT) begin
                        state_next       = ACCESS;
                        mem_address_next = sel_addr;
                        mem_data_in_next = sel_wdata;
                        mem_write_next   = sel_we;
                        mem_read_next    = !sel_we;
                    end else begin
                        // Rejected without touching memory: straight to ACK.
                        state_next = ACK;
                        if (sel_b) begin
                            b_ack_next   = 1'b1;
                            b_err_next   = 1'b1;
                            b_rdata_next = '0;
                        end else begin
                            a_ack_next   = 1'b1;
                            a_err_next   = 1'b1;
                            a_rdata_next = '0;
                        end
                    end
                end
            end
            ACCESS: begin
                state_next = ACK;
                busy_next  = 1'b1;
                if (grant_b_reg) begin
                    b_ack_next   = 1'b1;
                    b_rdata_next = we_reg ? '0 : mem_data_out;
                end else begin
                    a_ack_next   = 1'b1;
                    a_rdata_next = we_reg ? '0 : mem_data_out;
                end
            end
            ACK: begin
                // Strobes already low here, so every write sees a fresh rising edge.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            last_b_reg      <= 1'b1;
            grant_b_reg     <= 1'b0;
            we_reg          <= 1'b0;
            mem_address_reg <= '0;
            mem_data_in_reg <= '0;
            mem_write_reg   <= 1'b0;
            mem_read_reg    <= 1'b0;
            a_ack_reg       <= 1'b0;
            a_err_reg       <= 1'b0;
            a_rdata_reg     <= '0;
            b_ack_reg       <= 1'b0;
            b_err_reg       <= 1'b0;
            b_rdata_reg     <= '0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            last_b_reg      <= last_b_next;
            grant_b_reg     <= grant_b_next;
            we_reg          <= we_next;
            mem_address_reg <= mem_address_next;
            mem_data_in_reg <= mem_data_in_next;
            mem_write_reg   <= mem_write_next;
            mem_read_reg    <= mem_read_next;
            a_ack_reg       <= a_ack_next;
            a_err_reg       <= a_err_next;
            a_rdata_reg     <= a_rdata_next;
            b_ack_reg       <= b_ack_next;
            b_err_reg       <= b_err_next;
            b_rdata_reg     <= b_rdata_next;
            busy_reg        <= busy_next;
        end
    end

    assign a_ack       = a_ack_reg;
    assign a_err       = a_err_reg;
    assign a_rdata     = a_rdata_reg;
    assign b_ack       = b_ack_reg;
    assign b_err       = b_err_reg;
    assign b_rdata     = b_rdata_reg;
    assign mem_address = mem_address_reg;
    assign mem_data_in = mem_data_in_reg;
    assign mem_write   = mem_write_reg;
    assign mem_read    = mem_read_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a DMEM model, a cycle-timeline reference model of
// the arbiter, a per-cycle compare process, directed scenarios with literal
// expectations and two randomized requesters.
module tb_dmem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 256;

    logic          clk;
    logic          rst;
    logic          a_req, a_we, a_ack, a_err;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_ack, b_err;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in, mem_data_out;
    logic          mem_write, mem_read, busy;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int wr_cnt    = 0;
    int rd_cnt    = 0;
    int b_ack_cnt = 0;
    int ack_log[$];
    int ack_cyc[$];

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DMEM: combinational read, write on rising edge; word i starts as 0x10000000+i.
    logic [DW-1:0] dmem [DEPTH];
    assign mem_data_out = dmem[mem_address[7:0]];
    initial begin
        for (int i = 0; i < DEPTH; i++) dmem[i] = 32'h1000_0000 + 32'(i);
        forever begin
            @(posedge clk);
            if (mem_write) dmem[mem_address[7:0]] = mem_data_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected activity per cycle: ack port (1=A,2=B), err, rdata, strobe (1=rd,2=wr).
    typedef struct packed {
        logic [1:0]    ack;
        logic          err;
        logic [DW-1:0] rdata;
        logic [1:0]    strobe;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          busy;
    } ev_t;
    ev_t ring [16];
    logic [DW-1:0] ref_mem [DEPTH];

    // Reference model: on each sampled grant, schedule the whole transaction
    // on the timeline (strobe at +1, ack at +2; rejected address: ack at +1).
    initial begin : model
        int            cur, free_cyc, pw_cyc, p;
        bit            last_b, pw_valid, gb, we;
        logic [7:0]    pw_addr;
        logic [DW-1:0] pw_data, wd;
        logic [AW-1:0] ad;
        for (int i = 0; i < 16; i++) ring[i] = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
        free_cyc = 0; last_b = 1'b1; pw_valid = 1'b0; pw_cyc = 0;
        pw_addr = '0; pw_data = '0;
        forever begin
            @(posedge clk);
            cur = cyc;
            ring[4'(cur + 3)] = '0;
            if (rst) begin
                ring[4'(cur + 1)] = '0;
                ring[4'(cur + 2)] = '0;
                pw_valid = 1'b0;
                free_cyc = cur + 1;
                last_b   = 1'b1;
            end else begin
                if (pw_valid && pw_cyc == cur) begin
                    ref_mem[pw_addr] = pw_data;
                    pw_valid = 1'b0;
                end
                if (cur >= free_cyc && (a_req || b_req)) begin
                    if (a_req && b_req) begin
                        gb = !last_b;
                        last_b = gb;
                    end else begin
                        gb = b_req;
                    end
                    p  = gb ? 2 : 1;
                    we = gb ? b_we : a_we;
                    ad = gb ? b_addr : a_addr;
                    wd = gb ? b_wdata : a_wdata;
                    if (ad < DEPTH) begin
                        ring[4'(cur + 1)].strobe = we ? 2'd2 : 2'd1;
                        ring[4'(cur + 1)].addr   = ad;
                        ring[4'(cur + 1)].wdata  = wd;
                        ring[4'(cur + 1)].busy   = 1'b1;
                        ring[4'(cur + 2)].ack    = 2'(p);
                        ring[4'(cur + 2)].rdata  = we ? '0 : ref_mem[ad[7:0]];
                        ring[4'(cur + 2)].busy   = 1'b1;
                        if (we) begin
                            pw_valid = 1'b1; pw_cyc = cur + 1;
                            pw_addr = ad[7:0]; pw_data = wd;
                        end
                        free_cyc = cur + 3;
                    end else begin
                        ring[4'(cur + 1)].ack   = 2'(p);
                        ring[4'(cur + 1)].err   = 1'b1;
                        ring[4'(cur + 1)].rdata = '0;
                        ring[4'(cur + 1)].busy  = 1'b1;
                        free_cyc = cur + 2;
                    end
                end
            end
            cyc = cyc + 1;
        end
    end

    // Compare process: every cycle, mid-period, DUT outputs against the timeline.
    initial begin : compare
        logic [DW-1:0] ea_rd, eb_rd, e_wd;
        logic [AW-1:0] e_addr;
        ev_t e;
        ea_rd = '0; eb_rd = '0; e_wd = '0; e_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ctrl", 32'({a_ack, a_err, b_ack, b_err, mem_write, mem_read, busy}), 32'd0);
                chk("rst_a_rdata", a_rdata, 32'd0);
                chk("rst_b_rdata", b_rdata, 32'd0);
                chk("rst_mem_address", mem_address, 32'd0);
                chk("rst_mem_data_in", mem_data_in, 32'd0);
                ea_rd = '0; eb_rd = '0; e_wd = '0; e_addr = '0;
            end else begin
                e = ring[4'(cyc)];
                if (e.ack == 2'd1) ea_rd = e.rdata;
                if (e.ack == 2'd2) eb_rd = e.rdata;
                if (e.strobe != 2'd0) begin
                    e_addr = e.addr;
                    e_wd   = e.wdata;
                end
                chk("a_ack", 32'(a_ack), 32'(e.ack == 2'd1));
                chk("a_err", 32'(a_err), 32'(e.ack == 2'd1 && e.err));
                chk("b_ack", 32'(b_ack), 32'(e.ack == 2'd2));
                chk("b_err", 32'(b_err), 32'(e.ack == 2'd2 && e.err));
                chk("a_rdata", a_rdata, ea_rd);
                chk("b_rdata", b_rdata, eb_rd);
                chk("mem_read", 32'(mem_read), 32'(e.strobe == 2'd1));
                chk("mem_write", 32'(mem_write), 32'(e.strobe == 2'd2));
                chk("mem_address", mem_address, e_addr);
                chk("mem_data_in", mem_data_in, e_wd);
                chk("busy", 32'(busy), 32'(e.busy));
                if (mem_write) wr_cnt++;
                if (mem_read) rd_cnt++;
                if (b_ack) b_ack_cnt++;
            end
        end
    end

    // One request on port p (0=A, 1=B), held until its ack; starts and ends 2 units after an edge.
    task automatic txn(input int p, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input bit keep, output int lat);
        int n;
        bit got;
        if (p == 0) begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data; end
        else        begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data; end
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #2;
            n++;
            got = (p == 0) ? a_ack : b_ack;
        end
        lat = n;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL ack_timeout: port %0d addr %0h got no ack within %0d cycles", p, addr, n);
        end else begin
            ack_log.push_back(p);
            ack_cyc.push_back(cyc);
        end
        $display("txn port=%s we=%0d addr=%0h wdata=%0h lat=%0d err=%0d rdata=%0h",
                 (p == 0) ? "A" : "B", we, addr, data, lat,
                 (p == 0) ? a_err : b_err, (p == 0) ? a_rdata : b_rdata);
        if (!keep || !got) begin
            if (p == 0) a_req = 1'b0; else b_req = 1'b0;
        end
    endtask

    task automatic rand_port(input int p, input int count);
        int lat, gap;
        logic we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        bit keep;
        for (int k = 0; k < count; k++) begin
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom();
            keep = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) ad = 32'd256 + 32'($urandom_range(0, 5000));
            else                           ad = 32'($urandom_range(0, 255));
            txn(p, we, ad, wd, keep, lat);
            if (!keep) begin
                gap = $urandom_range(0, 3);
                if (gap > 0) begin
                    repeat (gap) @(posedge clk);
                    #2;
                end
            end
        end
        if (p == 0) a_req = 1'b0; else b_req = 1'b0;
    endtask

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat, w0, r0, bk;
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;

        // A write 5 <= DEADBEEF
        w0 = wr_cnt;
        txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, lat);
        chk("t2_latency", 32'(lat), 32'd2);
        chk("t2_a_err", 32'(a_err), 32'd0);
        chk("t2_write_pulses", 32'(wr_cnt - w0), 32'd1);
        chk("t2_dmem5", dmem[5], 32'hDEAD_BEEF);
        @(posedge clk); #2;

        // B read 5
        r0 = rd_cnt;
        txn(1, 1'b0, 32'd5, 32'd0, 1'b0, lat);
        chk("t3_latency", 32'(lat), 32'd2);
        chk("t3_b_rdata", b_rdata, 32'hDEAD_BEEF);
        chk("t3_b_err", 32'(b_err), 32'd0);
        chk("t3_read_pulses", 32'(rd_cnt - r0), 32'd1);
        @(posedge clk); #2;

        // Both ports hammering: alternation A,B,A,B at 3-cycle spacing
        ack_log.delete(); ack_cyc.delete();
        fork
            begin int la; txn(0, 1'b0, 32'd1, 32'd0, 1'b1, la); txn(0, 1'b0, 32'd1, 32'd0, 1'b0, la); end
            begin int lb; txn(1, 1'b0, 32'd2, 32'd0, 1'b1, lb); txn(1, 1'b0, 32'd2, 32'd0, 1'b0, lb); end
        join
        chk("t4_ack_count", 32'(ack_log.size()), 32'd4);
        if (ack_log.size() == 4) begin
            chk("t4_order0", 32'(ack_log[0]), 32'd0);
            chk("t4_order1", 32'(ack_log[1]), 32'd1);
            chk("t4_order2", 32'(ack_log[2]), 32'd0);
            chk("t4_order3", 32'(ack_log[3]), 32'd1);
            chk("t4_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
            chk("t4_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd3);
            chk("t4_gap3", 32'(ack_cyc[3] - ack_cyc[2]), 32'd3);
        end
        chk("t4_a_rdata", a_rdata, 32'h1000_0001);
        chk("t4_b_rdata", b_rdata, 32'h1000_0002);
        @(posedge clk); #2;

        // A read of out-of-range address 300
        w0 = wr_cnt; r0 = rd_cnt;
        txn(0, 1'b0, 32'd300, 32'd0, 1'b0, lat);
        chk("t5_latency", 32'(lat), 32'd1);
        chk("t5_a_err", 32'(a_err), 32'd1);
        chk("t5_a_rdata", a_rdata, 32'd0);
        chk("t5_no_strobes", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);
        @(posedge clk); #2;

        // Reset during the ACCESS cycle of a B write to 9
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'd9; b_wdata = 32'hCAFE_F00D;
        lat = 0;
        while (!mem_write && lat < 10) begin
            @(posedge clk); #2;
            lat++;
        end
        chk("t6_in_access", 32'(mem_write), 32'd1);
        bk = b_ack_cnt;
        rst = 1'b1; b_req = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        chk("t6_no_b_ack", 32'(b_ack_cnt - bk), 32'd0);
        chk("t6_busy_idle", 32'(busy), 32'd0);
        txn(1, 1'b0, 32'd9, 32'd0, 1'b0, lat);
        chk("t6_next_latency", 32'(lat), 32'd2);
        chk("t6_next_rdata", b_rdata, 32'h1000_0009);
        @(posedge clk); #2;

        // Randomized traffic from both ports
        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join
        @(posedge clk); #2;

        // Reset mid-run, then a tie must go to A
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd7;
        @(posedge clk); #2;
        rst = 1'b1; a_req = 1'b0;
        @(posedge clk); #2;
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_acks", 32'({a_ack, b_ack, a_err, b_err}), 32'd0);
        chk("t1_strobes", 32'({mem_read, mem_write}), 32'd0);
        chk("t1_a_rdata", a_rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #2;
        ack_log.delete(); ack_cyc.delete();
        fork
            begin int la; txn(0, 1'b0, 32'd3, 32'd0, 1'b0, la); end
            begin int lb; txn(1, 1'b0, 32'd4, 32'd0, 1'b0, lb); end
        join
        chk("t1_tie_count", 32'(ack_log.size()), 32'd2);
        if (ack_log.size() == 2) begin
            chk("t1_first_is_a", 32'(ack_log[0]), 32'd0);
            chk("t1_second_is_b", 32'(ack_log[1]), 32'd1);
        end
        repeat (3) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
